// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of a small combinational unit, captures its output
// into a truth table and scores it against a latched expected table.
module truth_table_scanner #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [2**N_IN-1:0]   expected_i,
   input  logic                 dut_d_i,
   output logic [N_IN-1:0]      vec_out_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2**N_IN-1:0]   table_out_o,
   output logic                 pass_o,
   output logic [N_IN:0]        mismatch_cnt_o
);

   // state   | meaning
   // S_IDLE  | waiting for start, vec_out parked at 0
   // S_DRIVE | holding vec_out for SETTLE cycles
   // S_SAMPLE| capturing dut_d for the current vector
   // S_DONE  | one-cycle completion pulse, results valid

   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NV-1:0]   exp_q, exp_d;
   logic [NV-1:0]   tbl_q, tbl_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   mcnt_q, mcnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tbl_q   <= '0;
         pass_q  <= 1'b0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         pass_q  <= pass_d;
         mcnt_q  <= mcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tbl_d   = tbl_q;
      pass_d  = pass_q;
      mcnt_d  = mcnt_q;

      case (state_q)
         S_IDLE: begin
            vec_d = '0;
            cnt_d = '0;
            if (start_i && !abort_i) begin
               exp_d   = expected_i;
               tbl_d   = '0;
               pass_d  = 1'b0;
               mcnt_d  = '0;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (abort_i) begin
               state_d = S_IDLE;
               vec_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SAMPLE: begin
            // abort discards the capture that would otherwise land this cycle
            if (abort_i) begin
               state_d = S_IDLE;
               vec_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end else begin
               tbl_d[vec_q] = dut_d_i;
               if (dut_d_i != exp_q[vec_q])
                  mcnt_d = mcnt_q + (N_IN+1)'(1);
               if (&vec_q) begin
                  pass_d  = (mcnt_d == '0);
                  state_d = S_DONE;
               end else begin
                  vec_d   = vec_q + N_IN'(1);
                  state_d = S_DRIVE;
               end
            end
         end
         S_DONE: begin
            vec_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            vec_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign vec_out_o      = vec_q;
   assign busy_o         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign done_o         = (state_q == S_DONE);
   assign table_out_o    = tbl_q;
   assign pass_o         = pass_q;
   assign mismatch_cnt_o = mcnt_q;

endmodule
